// File: rtl/mat_pkg.sv
// mat_pkg: shared job-controller types, default widths and routing-mode constants
package mat_pkg;
  localparam int DIM_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam logic MODE_BLOCK = 1'b0;
  localparam logic MODE_ALT = 1'b1;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
endpackage

// File: rtl/mat_elem_counter.sv
// mat_elem_counter: enable-qualified element counter with clear and done / last-minus-one compares
module mat_elem_counter
  import mat_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_total,
  output logic             o_done,
  output logic             o_last
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_en) r_cnt <= i_clr ? '0 : r_cnt + CNT_W'(i_inc);
  assign o_done = r_cnt == i_total;
  assign o_last = r_cnt == i_total - CNT_W'(1);
endmodule

// File: rtl/mat_job_ctrl.sv
// mat_job_ctrl: job-level controller steering one byte stream into A/B operand ports and tracking results
module mat_job_ctrl
  import mat_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clk_e,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [DIM_W-1:0] i_cfg_m,
  input  logic [DIM_W-1:0] i_cfg_k,
  input  logic [DIM_W-1:0] i_cfg_n,
  input  logic             i_cfg_mode,
  input  logic             i_abort,
  input  logic             s_axis_valid,
  output logic             s_axis_ready,
  output logic             m_axis_a_valid,
  input  logic             m_axis_a_ready,
  output logic             m_axis_b_valid,
  input  logic             m_axis_b_ready,
  input  logic             i_res_valid,
  input  logic             i_res_ready,
  output logic             o_res_last,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_cfg_err,
  output logic [7:0]       o_job_cnt
);
  state_t           r_state, w_nxt;
  logic             r_mode, r_tog, r_cfg_err;
  logic [CNT_W-1:0] r_ta, r_tb, r_tr;
  logic [7:0]       r_job_cnt;
  logic             w_idle, w_load, w_busy, w_cfg_ok, w_accept, w_abort, w_clr;
  logic             w_sel_a, w_up, w_res;
  logic             w_a_done, w_a_last, w_b_done, w_b_last, w_r_done, w_r_last;
  logic             w_a_fin, w_b_fin, w_r_fin;

  assign w_idle   = r_state == IDLE;
  assign w_load   = r_state == LOAD;
  assign w_busy   = !w_idle;
  assign w_cfg_ok = |i_cfg_m & |i_cfg_k & |i_cfg_n;
  assign w_accept = w_idle & i_cfg_valid & w_cfg_ok;
  assign w_abort  = i_abort & w_busy;
  assign w_clr    = w_idle | w_abort;

  // alternate mode follows the toggle until one side runs dry, then drains the other
  assign w_sel_a = (r_mode == MODE_ALT) ? (!w_a_done & (w_b_done | !r_tog)) : !w_a_done;

  assign m_axis_a_valid = w_load & w_sel_a & s_axis_valid;
  assign m_axis_b_valid = w_load & !w_sel_a & s_axis_valid;
  assign s_axis_ready   = w_load & (w_sel_a ? m_axis_a_ready : m_axis_b_ready);
  assign w_up  = s_axis_valid & s_axis_ready;
  assign w_res = i_res_valid & i_res_ready & (w_load | r_state == DRAIN) & !w_r_done;

  assign w_a_fin = w_a_done | (w_a_last & w_up & w_sel_a);
  assign w_b_fin = w_b_done | (w_b_last & w_up & !w_sel_a);
  assign w_r_fin = w_r_done | (w_r_last & w_res);

  mat_elem_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_clk_e), .i_clr(w_clr),
    .i_inc(w_up & w_sel_a), .i_total(r_ta), .o_done(w_a_done), .o_last(w_a_last)
  );
  mat_elem_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_clk_e), .i_clr(w_clr),
    .i_inc(w_up & !w_sel_a), .i_total(r_tb), .o_done(w_b_done), .o_last(w_b_last)
  );
  mat_elem_counter #(.CNT_W(CNT_W)) u_cnt_r (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_clk_e), .i_clr(w_clr),
    .i_inc(w_res), .i_total(r_tr), .o_done(w_r_done), .o_last(w_r_last)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = w_accept ? LOAD : IDLE;
      LOAD:    w_nxt = !(w_a_fin & w_b_fin) ? LOAD : w_r_fin ? DONE : DRAIN;
      DRAIN:   w_nxt = w_r_fin ? DONE : DRAIN;
      default: w_nxt = IDLE;
    endcase
    if (w_abort) w_nxt = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_mode    <= MODE_BLOCK;
      r_tog     <= 1'b0;
      r_cfg_err <= 1'b0;
      r_ta      <= '0;
      r_tb      <= '0;
      r_tr      <= '0;
      r_job_cnt <= '0;
    end else if (i_clk_e) begin
      r_state   <= w_nxt;
      r_cfg_err <= w_idle & i_cfg_valid & !w_cfg_ok;
      r_tog     <= w_clr ? 1'b0 : r_tog ^ w_up;
      if (w_accept) begin
        r_mode <= i_cfg_mode;
        r_ta   <= CNT_W'(i_cfg_m) * CNT_W'(i_cfg_k);
        r_tb   <= CNT_W'(i_cfg_k) * CNT_W'(i_cfg_n);
        r_tr   <= CNT_W'(i_cfg_m) * CNT_W'(i_cfg_n);
      end
      if (r_state == DONE && !w_abort) r_job_cnt <= r_job_cnt + 8'd1;
    end

  assign o_cfg_ready = w_idle & i_rst_n;
  assign o_busy      = w_busy;
  assign o_done      = r_state == DONE;
  assign o_cfg_err   = r_cfg_err;
  assign o_res_last  = w_busy & w_r_last;
  assign o_job_cnt   = r_job_cnt;
endmodule

// File: tb/tb_mat_job_ctrl.sv
// tb_mat_job_ctrl: directed jobs checked every cycle against a count-based job model plus literal expectations
module tb_mat_job_ctrl;
  logic       i_clk = 1'b0, i_rst_n = 1'b0, i_clk_e = 1'b1;
  logic       i_cfg_valid = 1'b0, i_cfg_mode = 1'b0, i_abort = 1'b0;
  logic [3:0] i_cfg_m = '0, i_cfg_k = '0, i_cfg_n = '0;
  logic       s_axis_valid = 1'b0, m_axis_a_ready = 1'b1, m_axis_b_ready = 1'b1;
  logic       i_res_valid = 1'b0, i_res_ready = 1'b1;
  logic       o_cfg_ready, s_axis_ready, m_axis_a_valid, m_axis_b_valid;
  logic       o_res_last, o_busy, o_done, o_cfg_err;
  logic [7:0] o_job_cnt;

  mat_job_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clk_e(i_clk_e),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_cfg_m(i_cfg_m), .i_cfg_k(i_cfg_k), .i_cfg_n(i_cfg_n), .i_cfg_mode(i_cfg_mode),
    .i_abort(i_abort), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .m_axis_a_valid(m_axis_a_valid), .m_axis_a_ready(m_axis_a_ready),
    .m_axis_b_valid(m_axis_b_valid), .m_axis_b_ready(m_axis_b_ready),
    .i_res_valid(i_res_valid), .i_res_ready(i_res_ready), .o_res_last(o_res_last),
    .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err), .o_job_cnt(o_job_cnt)
  );

  always #5 i_clk = ~i_clk;

  int ce_div = 1, ce_ph = 0;
  always @(posedge i_clk) begin
    #1;
    ce_ph = (ce_ph + 1) % ce_div;
    i_clk_e = (ce_ph == 0);
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // job model: phase is derived from element counts, not from a state machine
  int         ta = 0, tb = 0, tr = 0, na = 0, nb = 0, nr = 0;
  logic       e_mode = 1'b0, e_busy = 1'b0, e_donep = 1'b0, e_err = 1'b0;
  logic [7:0] e_jobs = '0;

  function automatic bit loading();
    return e_busy && !e_donep && !(na == ta && nb == tb);
  endfunction
  function automatic bit side_a();
    if (!e_mode) return na < ta;
    if (na == ta) return 1'b0;
    if (nb == tb) return 1'b1;
    return ((na + nb) % 2) == 0;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    bit up, sa, rs;
    int nna, nnb, nnr;
    if (!i_rst_n) begin
      e_busy <= 1'b0; e_donep <= 1'b0; e_err <= 1'b0; e_jobs <= '0;
      na <= 0; nb <= 0; nr <= 0;
    end else if (i_clk_e) begin
      e_err <= !e_busy && i_cfg_valid && (i_cfg_m == 0 || i_cfg_k == 0 || i_cfg_n == 0);
      if (e_busy && i_abort) begin
        e_busy <= 1'b0; e_donep <= 1'b0; na <= 0; nb <= 0; nr <= 0;
      end else if (e_donep) begin
        e_busy <= 1'b0; e_donep <= 1'b0; e_jobs <= e_jobs + 8'd1;
      end else if (!e_busy) begin
        if (i_cfg_valid && i_cfg_m != 0 && i_cfg_k != 0 && i_cfg_n != 0) begin
          e_busy <= 1'b1; e_mode <= i_cfg_mode;
          ta <= int'(i_cfg_m) * int'(i_cfg_k);
          tb <= int'(i_cfg_k) * int'(i_cfg_n);
          tr <= int'(i_cfg_m) * int'(i_cfg_n);
          na <= 0; nb <= 0; nr <= 0;
        end
      end else begin
        sa  = side_a();
        up  = loading() && s_axis_valid && (sa ? m_axis_a_ready : m_axis_b_ready);
        rs  = i_res_valid && i_res_ready && nr < tr;
        nna = na + int'(up && sa);
        nnb = nb + int'(up && !sa);
        nnr = nr + int'(rs);
        na <= nna; nb <= nnb; nr <= nnr;
        if (nna == ta && nnb == tb && nnr == tr) e_donep <= 1'b1;
      end
    end
  end

  int          cyc = 0, a_tot = 0, b_tot = 0, r_tot = 0, d_tot = 0;
  int          last_at = 0, last_cyc = 0, done_cyc = 0, busy_cnt = 0, en_busy = 0;
  logic [63:0] route = '0;
  always @(negedge i_clk) begin
    cyc <= cyc + 1;
    if (o_busy) busy_cnt <= busy_cnt + 1;
    if (i_clk_e) begin
      if (m_axis_a_valid && m_axis_a_ready) begin
        a_tot <= a_tot + 1; route <= {route[62:0], 1'b1};
      end else if (m_axis_b_valid && m_axis_b_ready) begin
        b_tot <= b_tot + 1; route <= {route[62:0], 1'b0};
      end
      if (i_res_valid && i_res_ready && o_busy && !o_done) begin
        r_tot <= r_tot + 1;
        if (o_res_last) begin last_at <= r_tot + 1; last_cyc <= cyc; end
      end
      if (o_done) begin d_tot <= d_tot + 1; done_cyc <= cyc; end
      if (o_busy) en_busy <= en_busy + 1;
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic send_cfg(input logic [3:0] m, input logic [3:0] k, input logic [3:0] n, input logic md);
    bit acc;
    int g = 0;
    i_cfg_m = m; i_cfg_k = k; i_cfg_n = n; i_cfg_mode = md; i_cfg_valid = 1'b1;
    do begin
      @(negedge i_clk);
      acc = i_clk_e && o_cfg_ready;
      tick();
      g++;
    end while (!acc && g < 50);
    i_cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int g = 0;
    while (o_busy && g < 300) begin tick(); g++; end
    chk(nm, 32'(o_busy), 0);
  endtask

  initial begin
    int a0, b0, r0, d0, s0;
    fork
      forever begin
        @(negedge i_clk);
        chk("outputs",
            {o_cfg_ready, s_axis_ready, m_axis_a_valid, m_axis_b_valid, o_res_last,
             o_busy, o_done, o_cfg_err, o_job_cnt},
            {i_rst_n & !e_busy, loading() & (side_a() ? m_axis_a_ready : m_axis_b_ready),
             loading() & side_a() & s_axis_valid, loading() & !side_a() & s_axis_valid,
             e_busy && (nr == tr - 1), e_busy, e_donep, e_err, e_jobs});
      end
    join_none
    #22 i_rst_n = 1'b1;
    tick();
    chk("reset_cfg_ready", 32'(o_cfg_ready), 1);
    chk("reset_busy", 32'(o_busy), 0);
    s_axis_valid = 1'b1;

    // block mode 2x3x2, results only after all bytes
    a0 = a_tot; r0 = r_tot; d0 = d_tot;
    send_cfg(4'd2, 4'd3, 4'd2, 1'b0);
    repeat (12) tick();
    i_res_valid = 1'b1;
    wait_idle("t1_finish");
    chk("t1_route", 32'(route[11:0]), 32'hFC0);
    chk("t1_a_bytes", a_tot - a0, 6);
    chk("t1_last_on_4th", last_at - r0, 4);
    chk("t1_done_gap", done_cyc - last_cyc, 1);
    chk("t1_done_pulses", d_tot - d0, 1);
    chk("t1_job_cnt", 32'(o_job_cnt), 1);

    // alternate mode 1x4x1, single result is the last one
    r0 = r_tot;
    send_cfg(4'd1, 4'd4, 4'd1, 1'b1);
    wait_idle("t2_finish");
    chk("t2_route", 32'(route[7:0]), 32'hAA);
    chk("t2_last_on_1st", last_at - r0, 1);
    chk("t2_job_cnt", 32'(o_job_cnt), 2);

    // B-side backpressure for 5 cycles
    a0 = a_tot; b0 = b_tot;
    send_cfg(4'd2, 4'd3, 4'd2, 1'b0);
    repeat (8) tick();
    m_axis_b_ready = 1'b0;
    s0 = b_tot;
    repeat (5) begin
      @(negedge i_clk);
      chk("t3_stall_ready", 32'(s_axis_ready), 0);
      tick();
    end
    chk("t3_stall_cb", b_tot - s0, 0);
    m_axis_b_ready = 1'b1;
    wait_idle("t3_finish");
    chk("t3_a_bytes", a_tot - a0, 6);
    chk("t3_b_bytes", b_tot - b0, 6);
    chk("t3_job_cnt", 32'(o_job_cnt), 3);

    // zero dimension rejected, then a 1x1x1 job
    send_cfg(4'd0, 4'd3, 4'd2, 1'b0);
    chk("t4_cfg_err", 32'(o_cfg_err), 1);
    chk("t4_busy", 32'(o_busy), 0);
    tick();
    chk("t4_cfg_err_clear", 32'(o_cfg_err), 0);
    send_cfg(4'd1, 4'd1, 4'd1, 1'b0);
    wait_idle("t4_finish");
    chk("t4_job_cnt", 32'(o_job_cnt), 4);

    // clock enable 1-of-3 on 2x2x2: 8 LOAD + 1 DONE enabled cycles
    ce_div = 3;
    s0 = busy_cnt; b0 = en_busy;
    send_cfg(4'd2, 4'd2, 4'd2, 1'b0);
    wait_idle("t5_finish");
    chk("t5_busy_cycles", busy_cnt - s0, 27);
    chk("t5_enabled_cycles", en_busy - b0, 9);
    chk("t5_job_cnt", 32'(o_job_cnt), 5);
    ce_div = 1;
    tick();

    // abort after 4 bytes of 3x3x3
    i_res_valid = 1'b0;
    d0 = d_tot;
    send_cfg(4'd3, 4'd3, 4'd3, 1'b0);
    repeat (4) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("t6_abort_busy", 32'(o_busy), 0);
    chk("t6_abort_ready", 32'(o_cfg_ready), 1);
    tick();
    chk("t6_abort_no_done", d_tot - d0, 0);
    chk("t6_abort_job_cnt", 32'(o_job_cnt), 5);

    // asynchronous reset while draining 3x3x3
    send_cfg(4'd3, 4'd3, 4'd3, 1'b0);
    repeat (18) tick();
    chk("t7_drain_busy", 32'(o_busy), 1);
    chk("t7_drain_ready", 32'(s_axis_ready), 0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("t7_async_reset",
        {o_cfg_ready, s_axis_ready, m_axis_a_valid, m_axis_b_valid, o_res_last,
         o_busy, o_done, o_cfg_err, o_job_cnt}, 0);
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("t7_ready_after", 32'(o_cfg_ready), 1);
    chk("t7_job_cnt_after", 32'(o_job_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
